// File: rtl/pipe_ts_rx.sv
// pipe_ts_rx: per-lane PCIe Gen1 TS1/TS2 receiver on the PIPE symbol stream.
// Frames and checks ordered sets, extracts fields, counts identical sets.
// Ports: clk, reset (async, high), clr (sync); rxdata/rxdatak/rxvalid/rxelecidle
// in; ts_valid/ts_err pulses, ts_type, field outputs, ts_cnt, ts1/ts2_done out.
module pipe_ts_rx #(
  parameter int unsigned NCONSEC = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [7:0] rxdata,
  input  logic       rxdatak,
  input  logic       rxvalid,
  input  logic       rxelecidle,
  output logic       ts_valid,
  output logic       ts_type,
  output logic [7:0] ts_link,
  output logic       ts_link_pad,
  output logic [7:0] ts_lane,
  output logic       ts_lane_pad,
  output logic [7:0] ts_nfts,
  output logic [7:0] ts_rate,
  output logic [7:0] ts_ctrl,
  output logic [7:0] ts_cnt,
  output logic       ts1_done,
  output logic       ts2_done,
  output logic       ts_err
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] ID_TS1 = 8'h4A;
  localparam logic [7:0] ID_TS2 = 8'h45;
  localparam logic [7:0] CNT_MAX = 8'(NCONSEC);

  logic [0:0] st_q, st_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] id_q, id_d;
  // staging for the set in flight; published only on a good symbol 15
  logic [7:0] slink_q, slink_d, slane_q, slane_d;
  logic       slpad_q, slpad_d, snpad_q, snpad_d;
  logic [7:0] snfts_q, snfts_d, srate_q, srate_d, sctrl_q, sctrl_d;

  logic       val_q, val_d, err_q, err_d, typ_q, typ_d;
  logic [7:0] link_q, link_d, lane_q, lane_d;
  logic       lpad_q, lpad_d, npad_q, npad_d;
  logic [7:0] nfts_q, nfts_d, rate_q, rate_d, ctrl_q, ctrl_d;
  logic [7:0] cnt_q, cnt_d;
  logic       d1_q, d1_d, d2_q, d2_d;

  logic is_com, is_pad, ok, same, new_typ;

  assign is_com  = rxdatak && (rxdata == COM);
  assign is_pad  = rxdatak && (rxdata == PAD);
  assign new_typ = (id_q == ID_TS2);

  // cnt_q==0 marks "no previous set to compare against"
  assign same = (cnt_q != 8'd0) && (new_typ == typ_q) &&
                (slink_q == link_q) && (slpad_q == lpad_q) &&
                (slane_q == lane_q) && (snpad_q == npad_q) &&
                (snfts_q == nfts_q) && (srate_q == rate_q) &&
                (sctrl_q == ctrl_q);

  always_comb begin
    ok = 1'b0;
    unique case (1'b1)
      (idx_q <= 4'd2):
        ok = !rxdatak || is_pad;
      (idx_q >= 4'd3 && idx_q <= 4'd5):
        ok = !rxdatak;
      (idx_q == 4'd6):
        ok = !rxdatak && (rxdata == ID_TS1 || rxdata == ID_TS2);
      (idx_q >= 4'd7):
        ok = !rxdatak && (rxdata == id_q);
    endcase
  end

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    id_d    = id_q;
    slink_d = slink_q;
    slpad_d = slpad_q;
    slane_d = slane_q;
    snpad_d = snpad_q;
    snfts_d = snfts_q;
    srate_d = srate_q;
    sctrl_d = sctrl_q;
    val_d   = 1'b0;
    err_d   = 1'b0;
    typ_d   = typ_q;
    link_d  = link_q;
    lpad_d  = lpad_q;
    lane_d  = lane_q;
    npad_d  = npad_q;
    nfts_d  = nfts_q;
    rate_d  = rate_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    if (clr) begin
      st_d  = IDLE;
      idx_d = 4'd0;
      cnt_d = 8'd0;
      d1_d  = 1'b0;
      d2_d  = 1'b0;
    end else if (rxelecidle) begin
      st_d  = IDLE;
      idx_d = 4'd0;
      cnt_d = 8'd0;
    end else if (rxvalid) begin
      if (st_q == IDLE) begin
        if (is_com) begin
          st_d  = COLLECT;
          idx_d = 4'd1;
        end
      end else if (is_com) begin
        // COM mid-set restarts framing; it is symbol 0 of the new set
        err_d = 1'b1;
        cnt_d = 8'd0;
        idx_d = 4'd1;
      end else if (!ok) begin
        err_d = 1'b1;
        cnt_d = 8'd0;
        st_d  = IDLE;
        idx_d = 4'd0;
      end else if (idx_q == 4'd15) begin
        val_d  = 1'b1;
        typ_d  = new_typ;
        link_d = slink_q;
        lpad_d = slpad_q;
        lane_d = slane_q;
        npad_d = snpad_q;
        nfts_d = snfts_q;
        rate_d = srate_q;
        ctrl_d = sctrl_q;
        if (!same) begin
          cnt_d = 8'd1;
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d == CNT_MAX) begin
          if (new_typ) d2_d = 1'b1;
          else         d1_d = 1'b1;
        end
        st_d  = IDLE;
        idx_d = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
        case (idx_q)
          4'd1: begin slink_d = rxdata; slpad_d = rxdatak; end
          4'd2: begin slane_d = rxdata; snpad_d = rxdatak; end
          4'd3: snfts_d = rxdata;
          4'd4: srate_d = rxdata;
          4'd5: sctrl_d = rxdata;
          4'd6: id_d    = rxdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      idx_q   <= 4'd0;
      id_q    <= 8'd0;
      slink_q <= 8'd0;
      slpad_q <= 1'b0;
      slane_q <= 8'd0;
      snpad_q <= 1'b0;
      snfts_q <= 8'd0;
      srate_q <= 8'd0;
      sctrl_q <= 8'd0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      typ_q   <= 1'b0;
      link_q  <= 8'd0;
      lpad_q  <= 1'b0;
      lane_q  <= 8'd0;
      npad_q  <= 1'b0;
      nfts_q  <= 8'd0;
      rate_q  <= 8'd0;
      ctrl_q  <= 8'd0;
      cnt_q   <= 8'd0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      slink_q <= slink_d;
      slpad_q <= slpad_d;
      slane_q <= slane_d;
      snpad_q <= snpad_d;
      snfts_q <= snfts_d;
      srate_q <= srate_d;
      sctrl_q <= sctrl_d;
      val_q   <= val_d;
      err_q   <= err_d;
      typ_q   <= typ_d;
      link_q  <= link_d;
      lpad_q  <= lpad_d;
      lane_q  <= lane_d;
      npad_q  <= npad_d;
      nfts_q  <= nfts_d;
      rate_q  <= rate_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign ts_valid    = val_q;
  assign ts_err      = err_q;
  assign ts_type     = typ_q;
  assign ts_link     = link_q;
  assign ts_link_pad = lpad_q;
  assign ts_lane     = lane_q;
  assign ts_lane_pad = npad_q;
  assign ts_nfts     = nfts_q;
  assign ts_rate     = rate_q;
  assign ts_ctrl     = ctrl_q;
  assign ts_cnt      = cnt_q;
  assign ts1_done    = d1_q;
  assign ts2_done    = d2_q;

endmodule
